fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning the program counter and instruction memory address width.
REQ-002 SHALL have parameter IW, default 12, meaning the instruction width: opcode in [11:8], operand in [7:0].
REQ-003 SHALL have port Clk  input  1  system clock; all state changes occur on the rising edge.
REQ-004 SHALL have port CLB  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ImemReq  output  1  fetch request to instruction memory.
REQ-006 SHALL have port ImemAddr  output  PC_W  fetch address, equal to PC.
REQ-007 SHALL have port ImemValid  input  1  instruction memory data valid.
REQ-008 SHALL have port ImemData  input  IW  fetched instruction.
REQ-009 SHALL have port Opcode  output  4  IR[11:8], consumed by controller_fsm.
REQ-010 SHALL have port Operand  output  8  IR[7:0], the register index or jump immediate.
REQ-011 SHALL have port InstrValid  output  1  execute strobe; Opcode and Operand are valid and controls are sampled.
REQ-012 SHALL have port LoadIR, IncPC, SelPC, LoadPC  input  1 each  controls from controller_fsm.
REQ-013 SHALL have port Z, C  input  1 each  accumulator zero and carry flags.
REQ-014 SHALL have port RegVal  input  PC_W  register-file value used as the jump target.
REQ-015 SHALL have ports PC  output  PC_W  and  Halted  output  1.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, EXEC and HALT.
REQ-017 IDLE SHALL last exactly one cycle after CLB deasserts, then go to FETCH.
REQ-018 In FETCH: ImemReq=1 and ImemAddr=PC, held stable until ImemValid=1 is sampled; on that edge IR<=ImemData and the state goes to EXEC.
REQ-019 ImemValid SHALL be ignored in any state other than FETCH.
REQ-020 EXEC SHALL last exactly one cycle with InstrValid=1; InstrValid SHALL be 0 in all other states.
REQ-021 On the EXEC edge, PC update: jump taken if LoadPC=1 and either (Opcode in {0110,0111} and Z=1) or (Opcode in {1000,1010} and C=1).
REQ-022 A taken jump SHALL load PC with Operand when SelPC=1, else with RegVal.
REQ-023 Otherwise PC<=PC+1 when IncPC=1, else PC holds.
REQ-024 A taken jump SHALL have priority over IncPC.
REQ-025 A not-taken conditional jump SHALL give PC<=PC+1 regardless of IncPC, so the branch falls through.
REQ-026 PC+1 SHALL wrap modulo 2^PC_W (0xFF -> 0x00).
REQ-027 Undefined opcodes (1001, 1110) SHALL ignore all controls: PC<=PC+1, and the state returns to FETCH.
REQ-028 From EXEC: if Opcode=1111 or LoadIR=0, go to HALT with PC unchanged; else go to FETCH.
REQ-029 HALT: Halted=1 and ImemReq=0; the block leaves HALT only on reset.
REQ-030 Fetch-to-execute latency SHALL be one cycle after ImemValid; with zero-wait memory, instruction throughput is one instruction per 2 cycles.

Reset
REQ-031 While CLB=0: PC=0, IR=0 (NOP), state=IDLE, ImemReq=0, InstrValid=0, Halted=0, all applied asynchronously.
REQ-032 Reset mid-fetch SHALL drop ImemReq immediately, and a late ImemValid SHALL be ignored.
REQ-033 Reset SHALL abort HALT.

Structure
REQ-034 Opcode constants, PC_W/IW defaults and the state encoding SHALL live in shared package cpu_pkg, also used by controller_fsm.
REQ-035 PC register, next-PC mux and branch-condition logic SHALL form sub-module pc_unit; the FSM and IR remain in fetch_unit.

Verification
REQ-036 Reset release, memory returns 0x000 at zero wait -> fetches from addresses 0,1,2 with InstrValid every 2nd cycle and PC incrementing.
REQ-037 JMPZ_IMM 0x7_42 with Z=1, LoadPC=1, SelPC=1 -> next ImemAddr=0x42; same instruction with Z=0 -> next ImemAddr=PC+1.
REQ-038 JMPC_REG with C=1, SelPC=0, RegVal=0x10, IncPC=0 -> next ImemAddr=0x10.
REQ-039 PC=0xFF executing NOP -> next ImemAddr=0x00; ImemValid delayed 3 cycles -> ImemAddr stable and ImemReq=1 throughout.
REQ-040 HALT 0xF00 -> Halted=1, ImemReq=0 and PC frozen for 20 cycles; CLB pulsed low mid-fetch -> PC=0 and ImemReq=0 asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, opcode constants, fetch FSM encoding and
// opcode-class helpers used by fetch_unit, pc_unit and controller_fsm.
package cpu_pkg;

   localparam int PC_W_DEF = 8;
   localparam int IW_DEF   = 12;

   localparam logic [3:0] OP_NOP      = 4'b0000;
   localparam logic [3:0] OP_JMPZ_REG = 4'b0110;
   localparam logic [3:0] OP_JMPZ_IMM = 4'b0111;
   localparam logic [3:0] OP_JMPC_REG = 4'b1000;
   localparam logic [3:0] OP_UNDEF_9  = 4'b1001;
   localparam logic [3:0] OP_JMPC_IMM = 4'b1010;
   localparam logic [3:0] OP_UNDEF_E  = 4'b1110;
   localparam logic [3:0] OP_HALT     = 4'b1111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } fetchState_t;

   function automatic logic isZJump(input logic [3:0] op);
      return (op == OP_JMPZ_REG) || (op == OP_JMPZ_IMM);
   endfunction

   function automatic logic isCJump(input logic [3:0] op);
      return (op == OP_JMPC_REG) || (op == OP_JMPC_IMM);
   endfunction

   function automatic logic isUndefOp(input logic [3:0] op);
      return (op == OP_UNDEF_9) || (op == OP_UNDEF_E);
   endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter with next-PC selection and branch-condition evaluation.
// The PC only moves on cycles where the fetch FSM asserts execEn.
module pc_unit
   import cpu_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
) (
   input  logic            Clk,
   input  logic            CLB,
   input  logic            execEn,
   input  logic [3:0]      opcode,
   input  logic [7:0]      operand,
   input  logic            incPc,
   input  logic            selPc,
   input  logic            loadPc,
   input  logic            z,
   input  logic            c,
   input  logic [PC_W-1:0] regVal,
   output logic [PC_W-1:0] pc
);

   logic [PC_W-1:0] pcInc;
   logic [PC_W-1:0] pcNext;
   logic            condJump;
   logic            taken;

   assign pcInc    = pc + PC_W'(1);
   assign condJump = isZJump(opcode) || isCJump(opcode);
   assign taken    = loadPc && ((isZJump(opcode) && z) || (isCJump(opcode) && c));

   // Undefined opcodes bypass every control; a conditional jump that is not
   // taken always falls through, independent of incPc.
   always_comb begin
      pcNext = pc;
      if (isUndefOp(opcode))
         pcNext = pcInc;
      else if (taken)
         pcNext = selPc ? PC_W'(operand) : regVal;
      else if (condJump || incPc)
         pcNext = pcInc;
   end

   always_ff @(posedge Clk or negedge CLB) begin
      if (!CLB)
         pc <= '0;
      else if (execEn)
         pc <= pcNext;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: requests an instruction at PC, latches it into IR,
// presents it for one execute cycle, then fetches again or halts.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int PC_W = PC_W_DEF,
   parameter int IW   = IW_DEF
) (
   input  logic            Clk,
   input  logic            CLB,
   output logic            ImemReq,
   output logic [PC_W-1:0] ImemAddr,
   input  logic            ImemValid,
   input  logic [IW-1:0]   ImemData,
   output logic [3:0]      Opcode,
   output logic [7:0]      Operand,
   output logic            InstrValid,
   input  logic            LoadIR,
   input  logic            IncPC,
   input  logic            SelPC,
   input  logic            LoadPC,
   input  logic            Z,
   input  logic            C,
   input  logic [PC_W-1:0] RegVal,
   output logic [PC_W-1:0] PC,
   output logic            Halted
);

   fetchState_t   state;
   logic [IW-1:0] ir;
   logic          goHalt;
   logic          execEn;

   assign Opcode   = ir[IW-1 -: 4];
   assign Operand  = ir[7:0];
   assign ImemAddr = PC;

   // Undefined opcodes never halt, even with LoadIR low.
   assign goHalt = !isUndefOp(Opcode) && ((Opcode == OP_HALT) || !LoadIR);
   assign execEn = (state == EXEC) && !goHalt;

   always_ff @(posedge Clk or negedge CLB) begin
      if (!CLB) begin
         state      <= IDLE;
         ir         <= '0;
         ImemReq    <= 1'b0;
         InstrValid <= 1'b0;
         Halted     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state   <= FETCH;
               ImemReq <= 1'b1;
            end
            FETCH: begin
               if (ImemValid) begin
                  ir         <= ImemData;
                  state      <= EXEC;
                  ImemReq    <= 1'b0;
                  InstrValid <= 1'b1;
               end
            end
            EXEC: begin
               InstrValid <= 1'b0;
               if (goHalt) begin
                  state  <= HALT;
                  Halted <= 1'b1;
               end else begin
                  state   <= FETCH;
                  ImemReq <= 1'b1;
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state      <= IDLE;
               ImemReq    <= 1'b0;
               InstrValid <= 1'b0;
               Halted     <= 1'b0;
            end
         endcase
      end
   end

   pc_unit #(.PC_W(PC_W)) uPcUnit (
      .Clk    (Clk),
      .CLB    (CLB),
      .execEn (execEn),
      .opcode (Opcode),
      .operand(Operand),
      .incPc  (IncPC),
      .selPc  (SelPC),
      .loadPc (LoadPC),
      .z      (Z),
      .c      (C),
      .regVal (RegVal),
      .pc     (PC)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, randomized
// instruction stream against a reference model, and reset/halt sequences.
module tb_fetch_unit;

   logic        Clk;
   logic        CLB;
   logic        ImemReq;
   logic [7:0]  ImemAddr;
   logic        ImemValid;
   logic [11:0] ImemData;
   logic [3:0]  Opcode;
   logic [7:0]  Operand;
   logic        InstrValid;
   logic        LoadIR, IncPC, SelPC, LoadPC, Z, C;
   logic [7:0]  RegVal;
   logic [7:0]  PC;
   logic        Halted;

   int   checks = 0;
   int   errors = 0;
   logic [7:0] mPc;
   time  lastExecT = 0;
   time  prevExecT = 0;

   typedef struct {
      string       name;
      logic [11:0] instr;
      logic        lir, inc, sel, lpc, zf, cf;
      logic [7:0]  rv;
      int          waitCyc;
      logic        expHalt;
      logic [7:0]  expPc;
   } vec_t;

   vec_t vecs[13];

   fetch_unit #(.PC_W(8), .IW(12)) dut (
      .Clk       (Clk),
      .CLB       (CLB),
      .ImemReq   (ImemReq),
      .ImemAddr  (ImemAddr),
      .ImemValid (ImemValid),
      .ImemData  (ImemData),
      .Opcode    (Opcode),
      .Operand   (Operand),
      .InstrValid(InstrValid),
      .LoadIR    (LoadIR),
      .IncPC     (IncPC),
      .SelPC     (SelPC),
      .LoadPC    (LoadPC),
      .Z         (Z),
      .C         (C),
      .RegVal    (RegVal),
      .PC        (PC),
      .Halted    (Halted)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Architectural outcome of one executed instruction: {halt, next PC}.
   function automatic logic [8:0] refStep(input int pc, input logic [11:0] instr,
                                          input logic lir, inc, sel, lpc, zf, cf,
                                          input int rv);
      int op;
      int opnd;
      int nxt;
      op   = int'(instr) / 256;
      opnd = int'(instr) % 256;
      if (op == 9 || op == 14) return {1'b0, 8'((pc + 1) % 256)};
      if (op == 15 || !lir)    return {1'b1, 8'(pc)};
      if (op == 6 || op == 7 || op == 8 || op == 10) begin
         if (lpc && (((op == 6 || op == 7) && zf) || ((op == 8 || op == 10) && cf)))
            nxt = sel ? opnd : rv;
         else
            nxt = (pc + 1) % 256;
      end else begin
         nxt = inc ? (pc + 1) % 256 : pc;
      end
      return {1'b0, 8'(nxt)};
   endfunction

   task automatic randomCtrls();
      {LoadIR, IncPC, SelPC, LoadPC, Z, C} = 6'($urandom);
      RegVal = 8'($urandom);
   endtask

   task automatic runInstr(input string nm, input logic [11:0] instr,
                           input logic lir, inc, sel, lpc, zf, cf,
                           input logic [7:0] rv, input int waitCyc,
                           input logic expHalt, input logic [7:0] expPc);
      int n = 0;
      while (!ImemReq && n < 10) begin
         @(negedge Clk);
         n++;
      end
      chk({nm, ".reqSeen"}, 32'(ImemReq), 1);
      if (!ImemReq) return;
      chk({nm, ".fetchAddr"}, 32'(ImemAddr), 32'(mPc));
      for (int i = 0; i < waitCyc; i++) begin
         ImemValid = 1'b0;
         ImemData  = 12'($urandom);
         randomCtrls();
         @(negedge Clk);
         chk({nm, ".waitReq"}, 32'(ImemReq), 1);
         chk({nm, ".waitAddr"}, 32'(ImemAddr), 32'(mPc));
         chk({nm, ".waitIV"}, 32'(InstrValid), 0);
      end
      ImemValid = 1'b1;
      ImemData  = instr;
      randomCtrls();
      @(negedge Clk);
      prevExecT = lastExecT;
      lastExecT = $time;
      chk({nm, ".execIV"}, 32'(InstrValid), 1);
      chk({nm, ".opcode"}, 32'(Opcode), 32'(instr[11:8]));
      chk({nm, ".operand"}, 32'(Operand), 32'(instr[7:0]));
      chk({nm, ".execReq"}, 32'(ImemReq), 0);
      // memory data offered during execute must not reach IR
      ImemValid = 1'b1;
      ImemData  = ~instr;
      {LoadIR, IncPC, SelPC, LoadPC, Z, C} = {lir, inc, sel, lpc, zf, cf};
      RegVal = rv;
      @(negedge Clk);
      ImemValid = 1'b0;
      chk({nm, ".halted"}, 32'(Halted), 32'(expHalt));
      chk({nm, ".pc"}, 32'(PC), 32'(expPc));
      chk({nm, ".postIV"}, 32'(InstrValid), 0);
      chk({nm, ".postReq"}, 32'(ImemReq), 32'(!expHalt));
      chk({nm, ".irKept"}, 32'(Opcode), 32'(instr[11:8]));
      mPc = expPc;
      randomCtrls();
   endtask

   task automatic runModel(input string nm, input logic [11:0] instr,
                           input logic lir, inc, sel, lpc, zf, cf,
                           input logic [7:0] rv, input int waitCyc);
      logic [8:0] r;
      r = refStep(int'(mPc), instr, lir, inc, sel, lpc, zf, cf, int'(rv));
      runInstr(nm, instr, lir, inc, sel, lpc, zf, cf, rv, waitCyc, r[8], r[7:0]);
   endtask

   task automatic freezeCheck(input string nm, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         ImemValid = 1'($urandom);
         ImemData  = 12'($urandom);
         randomCtrls();
         @(negedge Clk);
         chk({nm, ".halted"}, 32'(Halted), 1);
         chk({nm, ".req"}, 32'(ImemReq), 0);
         chk({nm, ".pc"}, 32'(PC), 32'(mPc));
         chk({nm, ".iv"}, 32'(InstrValid), 0);
      end
      ImemValid = 1'b0;
   endtask

   // Asynchronous reset pulse placed away from clock edges, with a stale
   // memory response held high through reset and the IDLE cycle.
   task automatic resetPulse(input string nm);
      @(negedge Clk);
      #2 CLB = 1'b0;
      #1;
      chk({nm, ".asyncReq"}, 32'(ImemReq), 0);
      chk({nm, ".asyncPc"}, 32'(PC), 0);
      chk({nm, ".asyncHalted"}, 32'(Halted), 0);
      chk({nm, ".asyncIV"}, 32'(InstrValid), 0);
      ImemValid = 1'b1;
      ImemData  = 12'h7AB;
      @(negedge Clk);
      CLB = 1'b1;
      #1 chk({nm, ".idleReq"}, 32'(ImemReq), 0);
      @(negedge Clk);
      chk({nm, ".fetchReq"}, 32'(ImemReq), 1);
      chk({nm, ".fetchAddr"}, 32'(ImemAddr), 0);
      chk({nm, ".lateValidIgnored"}, 32'(InstrValid), 0);
      chk({nm, ".irNop"}, 32'({Opcode, Operand}), 0);
      ImemValid = 1'b0;
      mPc = 8'h00;
   endtask

   initial begin
      vecs[0]  = '{"jmpzImmTaken",    12'h742, 1, 1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h42};
      vecs[1]  = '{"jmpzImmNotTaken", 12'h742, 1, 0, 1, 1, 0, 0, 8'h00, 0, 0, 8'h43};
      vecs[2]  = '{"jmpcReg",         12'h800, 1, 0, 0, 1, 0, 1, 8'h10, 0, 0, 8'h10};
      vecs[3]  = '{"jmpzReg",         12'h600, 1, 1, 0, 1, 1, 0, 8'h80, 1, 0, 8'h80};
      vecs[4]  = '{"jmpcImm",         12'hA33, 1, 0, 1, 1, 0, 1, 8'h99, 0, 0, 8'h33};
      vecs[5]  = '{"jmpcNotTaken",    12'hA44, 1, 0, 1, 1, 1, 0, 8'h99, 0, 0, 8'h34};
      vecs[6]  = '{"jumpToFF",        12'h7FF, 1, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'hFF};
      vecs[7]  = '{"wrapNopWait3",    12'h000, 1, 1, 0, 0, 0, 0, 8'h00, 3, 0, 8'h00};
      vecs[8]  = '{"nopHold",         12'h000, 1, 0, 1, 1, 1, 1, 8'h55, 0, 0, 8'h00};
      vecs[9]  = '{"undef9",          12'h9AB, 0, 0, 1, 1, 1, 1, 8'h77, 0, 0, 8'h01};
      vecs[10] = '{"undefE",          12'hE12, 0, 0, 0, 1, 1, 1, 8'h77, 1, 0, 8'h02};
      vecs[11] = '{"otherOpNoJump",   12'h355, 1, 1, 1, 1, 1, 1, 8'h66, 0, 0, 8'h03};
      vecs[12] = '{"jumpPriority",    12'h8C0, 1, 1, 1, 1, 0, 1, 8'h00, 2, 0, 8'hC0};

      CLB = 1'b0;
      ImemValid = 1'b0;
      ImemData  = '0;
      {LoadIR, IncPC, SelPC, LoadPC, Z, C} = '0;
      RegVal = '0;
      mPc = 8'h00;

      @(negedge Clk);
      chk("rst.pc", 32'(PC), 0);
      chk("rst.req", 32'(ImemReq), 0);
      chk("rst.iv", 32'(InstrValid), 0);
      chk("rst.halted", 32'(Halted), 0);
      chk("rst.ir", 32'({Opcode, Operand}), 0);
      CLB = 1'b1;
      #1 chk("idle.req", 32'(ImemReq), 0);
      @(negedge Clk);
      chk("idle.toFetch", 32'(ImemReq), 1);

      // zero-wait NOP stream: one instruction every two cycles
      for (int i = 0; i < 3; i++) begin
         runInstr("nopStream", 12'h000, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 8'(i + 1));
         if (i > 0) chk("nopStream.period", 32'(lastExecT - prevExecT), 20);
      end

      foreach (vecs[i])
         runInstr(vecs[i].name, vecs[i].instr, vecs[i].lir, vecs[i].inc, vecs[i].sel,
                  vecs[i].lpc, vecs[i].zf, vecs[i].cf, vecs[i].rv, vecs[i].waitCyc,
                  vecs[i].expHalt, vecs[i].expPc);

      for (int i = 0; i < 60; i++) begin
         logic [3:0]  op;
         logic [11:0] instr;
         logic        lir, lpc;
         op = 4'($urandom_range(0, 14));
         instr = {op, 8'($urandom)};
         lir = (op == 4'h9 || op == 4'hE) ? 1'($urandom) : 1'b1;
         lpc = (op == 4'h6 || op == 4'h7 || op == 4'h8 || op == 4'hA) ? 1'b1 : 1'($urandom);
         runModel("rand", instr, lir, 1'($urandom), 1'($urandom), lpc,
                  1'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 3));
      end

      runInstr("preResetJump", 12'h742, 1, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h42);
      chk("preReset.inFetch", 32'(ImemReq), 1);
      resetPulse("midFetchReset");
      runModel("afterReset", 12'h000, 1, 1, 0, 0, 0, 0, 8'h00, 0);

      runModel("loadIrLowHalt", 12'h742, 0, 1, 1, 1, 1, 0, 8'h00, 0);
      freezeCheck("loadIrLowFrozen", 5);
      resetPulse("haltAbort");
      runModel("afterAbort", 12'h7F0, 1, 0, 1, 1, 1, 0, 8'h00, 1);

      runModel("haltInstr", 12'hF00, 1, 1, 1, 1, 1, 1, 8'h12, 0);
      chk("haltInstr.pcKept", 32'(PC), 32'hF0);
      freezeCheck("haltFrozen", 20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
